// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transmitter:
//   - parity mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - frame engine state type tx_state_t
//   - calc_div(): bit period in clock cycles, rounded to nearest
//   - parity_bit(): final parity bit from the running XOR of the payload
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_EVEN = 32'sd1;
  localparam int PAR_ODD  = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Nearest-integer division so the line rate error is at most half a cycle.
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + (baud / 64'sd2)) / baud);
  endfunction

  // acc is the XOR of all payload bits; odd parity inverts it.
  function automatic logic parity_bit(input logic acc, input int mode);
    if (mode == PAR_ODD) begin
      return ~acc;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO. rd_data_o always shows the head
// entry while empty_o is low. Pushes while full and pops while empty are
// ignored, so a producer holding data against a full FIFO loses nothing.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (flushes the FIFO)
//   push_i         write wr_data_i (taken only when not full)
//   pop_i          drop the head entry (taken only when not empty)
//   wr_data_i      write data
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
//   count_o        number of entries stored
//   rd_data_o      head entry (combinational)
// ----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         rd_data_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_push = push_i & ~w_full;
  assign w_do_pop  = pop_i & ~w_empty;

  assign full_o    = w_full;
  assign empty_o   = w_empty;
  assign count_o   = r_count;
  assign rd_data_o = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with an input FIFO. Bytes are accepted with a
// valid/ready handshake, queued, and sent LSB first as
// start / DATA_BITS data / optional parity / STOP_BITS stop, with queued
// frames following each other without any idle bit.
// Ports:
//   clk_i          system clock (CLK_HZ)
//   rst_i          asynchronous active-high reset; aborts any frame in flight
//   tx_data_i      byte to send; bits above DATA_BITS-1 are never transmitted
//   tx_valid_i     producer offers tx_data_i
//   tx_ready_o     FIFO not full; word accepted when tx_valid_i & tx_ready_o
//   TXD_o          serial line, idle high, registered
//   busy_o         a frame is on the line
//   fifo_count_o   entries queued
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          TXD_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_error
    $error("uart_tx_fifo: illegal parameter set (DIV must be >= 4)");
  end

  tx_state_t r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_txd;
  logic          r_busy;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_fifo_data;
  logic          w_push;
  logic          w_tick;
  logic          w_load;
  logic          w_par_bit;

  assign w_push = tx_valid_i & ~w_fifo_full;
  assign w_tick = (r_baud_cnt == CW'(DIV - 1));

  // A new frame is loaded either from idle or on the final stop-bit wrap, so
  // consecutive frames abut with no idle cycle.
  assign w_load = ~w_fifo_empty &
                  ((r_state == ST_IDLE) |
                   ((r_state == ST_STOP) & w_tick & (r_bit_idx == LAST_STOP)));

  assign w_par_bit = parity_bit(r_par, PARITY);

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .pop_i     (w_load),
    .wr_data_i (tx_data_i),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .count_o   (fifo_count_o),
    .rd_data_o (w_fifo_data)
  );

  assign tx_ready_o = ~w_fifo_full;
  assign TXD_o      = r_txd;
  assign busy_o     = r_busy;

  // Bit-period counter: held at zero while idle, wraps every DIV cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_baud_cnt <= {CW{1'b0}};
    end else if (r_state == ST_IDLE) begin
      r_baud_cnt <= {CW{1'b0}};
    end else if (w_tick) begin
      r_baud_cnt <= {CW{1'b0}};
    end else begin
      r_baud_cnt <= r_baud_cnt + CW'(1);
    end
  end

  // Frame engine: state, shift register, parity accumulator and line driver.
  // The shifter keeps all 8 bits; bits above DATA_BITS-1 simply never reach
  // the line because the data phase ends after DATA_BITS shifts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_shift <= w_fifo_data;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end else begin
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        ST_START: begin
          if (w_tick) begin
            r_txd     <= r_shift[0];
            r_par     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'd0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= 3'd0;
              if (PARITY != PAR_NONE) begin
                r_txd   <= w_par_bit;
                r_state <= ST_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_txd     <= r_shift[0];
              r_par     <= r_par ^ r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        ST_PARITY: begin
          if (w_tick) begin
            r_txd     <= 1'b1;
            r_bit_idx <= 3'd0;
            r_state   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_idx != LAST_STOP) begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end else if (w_load) begin
              r_shift   <= w_fifo_data;
              r_txd     <= 1'b0;
              r_bit_idx <= 3'd0;
              r_state   <= ST_START;
            end else begin
              r_txd     <= 1'b1;
              r_busy    <= 1'b0;
              r_bit_idx <= 3'd0;
              r_state   <= ST_IDLE;
            end
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Six transmitter instances with different parameter sets share clock and
// reset; a selector routes the handshake and observed outputs to the one
// under test. Frame waveforms are checked cycle-exactly against hand-written
// line patterns (one character per bit slot, start bit first).
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         sel;

  logic       txd_a   [6];
  logic       busy_a  [6];
  logic       ready_a [6];
  logic [4:0] cnt_a   [6];
  logic [2:0] cnt_small;

  logic       txd;
  logic       busy;
  logic       ready;
  logic [4:0] count;

  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1  1: 8E1  2: 8O1  3: 7N2  4: 8N1 depth 4  5: 8N1 at 100 MHz / 9600
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 0)),
    .tx_ready_o(ready_a[0]), .TXD_o(txd_a[0]), .busy_o(busy_a[0]), .fifo_count_o(cnt_a[0]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 1)),
    .tx_ready_o(ready_a[1]), .TXD_o(txd_a[1]), .busy_o(busy_a[1]), .fifo_count_o(cnt_a[1]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 2)),
    .tx_ready_o(ready_a[2]), .TXD_o(txd_a[2]), .busy_o(busy_a[2]), .fifo_count_o(cnt_a[2]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 3)),
    .tx_ready_o(ready_a[3]), .TXD_o(txd_a[3]), .busy_o(busy_a[3]), .fifo_count_o(cnt_a[3]));

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_full (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 4)),
    .tx_ready_o(ready_a[4]), .TXD_o(txd_a[4]), .busy_o(busy_a[4]), .fifo_count_o(cnt_small));

  uart_tx_fifo #(.CLK_HZ(100_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_fast (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid && (sel == 5)),
    .tx_ready_o(ready_a[5]), .TXD_o(txd_a[5]), .busy_o(busy_a[5]), .fifo_count_o(cnt_a[5]));

  assign cnt_a[4] = {2'b00, cnt_small};

  // Route the selected instance's outputs to the checking signals.
  always_comb begin
    txd   = 1'b1;
    busy  = 1'b0;
    ready = 1'b0;
    count = 5'd0;
    case (sel)
      0: begin txd = txd_a[0]; busy = busy_a[0]; ready = ready_a[0]; count = cnt_a[0]; end
      1: begin txd = txd_a[1]; busy = busy_a[1]; ready = ready_a[1]; count = cnt_a[1]; end
      2: begin txd = txd_a[2]; busy = busy_a[2]; ready = ready_a[2]; count = cnt_a[2]; end
      3: begin txd = txd_a[3]; busy = busy_a[3]; ready = ready_a[3]; count = cnt_a[3]; end
      4: begin txd = txd_a[4]; busy = busy_a[4]; ready = ready_a[4]; count = cnt_a[4]; end
      5: begin txd = txd_a[5]; busy = busy_a[5]; ready = ready_a[5]; count = cnt_a[5]; end
      default: begin txd = 1'b1; busy = 1'b0; ready = 1'b0; count = 5'd0; end
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer one byte; returns #1 after the accepting edge. Data is scrambled
  // afterwards to show that queued bytes do not follow tx_data.
  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  // line[k] is the level of bit slot k (slot 0 = start bit), 10 cycles each.
  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nslots;
    logic [0:11] line;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int bad [12];
  int nbusy;
  int len;
  int nlow;
  int feed_next;
  logic feed_acc;
  logic seen_full;
  int fbad [6];
  int busy_low;

  initial begin
    n_pass   = 0;
    n_total  = 0;
    sel      = 0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rst      = 1'b1;

    vecs[0] = '{0, 8'h55, 10, 12'b0101_0101_0100};  // 8N1
    vecs[1] = '{0, 8'hA3, 10, 12'b0110_0010_1100};  // 8N1
    vecs[2] = '{1, 8'h41, 11, 12'b0100_0001_0010};  // 8E1, parity 0
    vecs[3] = '{2, 8'h41, 11, 12'b0100_0001_0110};  // 8O1, parity 1
    vecs[4] = '{2, 8'h00, 11, 12'b0000_0000_0110};  // 8O1, parity 1
    vecs[5] = '{1, 8'hFF, 11, 12'b0111_1111_1010};  // 8E1, parity 0
    vecs[6] = '{3, 8'hC1, 10, 12'b0100_0001_1100};  // 7N2, bit 7 dropped
    vecs[7] = '{3, 8'h80, 10, 12'b0000_0000_1100};  // 7N2, only bit 7 set

    // Reset state of every instance while reset is held.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 6; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst_txd[%0d]", s), txd, 1);
      chk($sformatf("rst_busy[%0d]", s), busy, 0);
      chk($sformatf("rst_ready[%0d]", s), ready, 1);
      chk($sformatf("rst_count[%0d]", s), count, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Single frames, checked cycle by cycle.
    for (int v = 0; v < NVEC; v++) begin
      sel = vecs[v].sel;
      len = vecs[v].nslots * 10;
      push_byte(vecs[v].data);
      chk($sformatf("v%0d_txd_accept_edge", v), txd, 1);
      chk($sformatf("v%0d_count_after_push", v), count, 1);
      @(posedge clk);
      #1;
      nbusy = 0;
      for (int s = 0; s < 12; s++) bad[s] = 0;
      for (int c = 0; c < len; c++) begin
        if (txd !== vecs[v].line[c / 10]) bad[c / 10]++;
        if (busy) nbusy++;
        @(posedge clk);
        #1;
      end
      for (int s = 0; s < vecs[v].nslots; s++) begin
        chk($sformatf("v%0d_slot%0d_bad_cycles", v, s), bad[s], 0);
      end
      chk($sformatf("v%0d_busy_cycles", v), nbusy, len);
      chk($sformatf("v%0d_txd_after", v), txd, 1);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
    end

    // Depth-4 FIFO, producer holds valid for six bytes 0x01..0x06.
    sel       = 4;
    seen_full = 1'b0;
    feed_next = 1;
    for (int f = 0; f < 6; f++) fbad[f] = 0;
    busy_low  = 0;
    @(negedge clk);
    tx_data  = 8'd1;
    tx_valid = 1'b1;
    fork
      begin
        for (int g = 0; g < 400 && feed_next <= 6; g++) begin
          feed_acc = ready;
          @(posedge clk);
          #1;
          if (feed_acc) begin
            feed_next++;
            if (feed_next > 6) tx_valid = 1'b0;
            else tx_data = 8'(feed_next);
          end
          if (!ready && !seen_full) begin
            seen_full = 1'b1;
            chk("full_count_at_ready_low", count, 4);
            chk("full_busy_at_ready_low", busy, 1);
          end
          if (feed_next <= 6) @(negedge clk);
        end
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
          automatic int f    = c / 100;
          automatic int slot = (c % 100) / 10;
          automatic int byt  = f + 1;
          automatic logic e  = (slot == 0) ? 1'b0 :
                               (slot == 9) ? 1'b1 : 1'((byt >> (slot - 1)) & 1);
          if (txd !== e) fbad[f]++;
          if (!busy) busy_low++;
          @(posedge clk);
          #1;
        end
      end
    join
    chk("full_all_bytes_accepted", feed_next, 7);
    chk("full_ready_dropped", seen_full, 1);
    for (int f = 0; f < 6; f++) chk($sformatf("b2b_frame%0d_bad_cycles", f), fbad[f], 0);
    chk("b2b_busy_low_cycles", busy_low, 0);
    chk("b2b_txd_after", txd, 1);
    chk("b2b_busy_after", busy, 0);
    chk("b2b_count_after", count, 0);

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    sel = 0;
    push_byte(8'hA5);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (42) @(posedge clk);
    #1;
    chk("mid_txd_bit3", txd, 0);
    chk("mid_count", count, 2);
    chk("mid_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", ready, 1);
    @(negedge clk);
    rst  = 1'b0;
    nlow = 0;
    nbusy = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) nlow++;
      if (busy) nbusy++;
    end
    chk("post_rst_txd_low_cycles", nlow, 0);
    chk("post_rst_busy_cycles", nbusy, 0);
    push_byte(8'h3C);
    chk("post_rst_txd_accept_edge", txd, 1);
    @(posedge clk);
    #1;
    chk("post_rst_start", txd, 0);

    // DIV = 10417 at 100 MHz / 9600: start bit length.
    sel = 5;
    push_byte(8'hFF);
    chk("fast_txd_accept_edge", txd, 1);
    @(posedge clk);
    #1;
    chk("fast_start_low", txd, 0);
    nlow = 1;
    while (txd === 1'b0 && nlow < 12000) begin
      @(posedge clk);
      #1;
      if (txd === 1'b0) nlow++;
    end
    chk("fast_start_cycles", nlow, 10417);
    chk("fast_bit0_high", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
